// File: rtl/mult_shift_add.sv
// Sequential shift-and-add multiplier with its own control FSM.
// The initiator raises init in IDLE; the block walks the multiplier
// bits LSB first, adding the shifted multiplicand for every set bit.
// It stops as soon as the remaining multiplier bits are all zero, so
// high zero bits cost no cycles. A one-cycle done strobe marks a
// valid product. pp then holds until the next accepted init or reset.
module mult_shift_add #(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               init,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] pp,
  output logic               done,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [PW-1:0]    pp_reg, pp_next;
  logic [PW-1:0]    a_reg, a_next;     // zero-extended, shifted multiplicand
  logic [WIDTH-1:0] b_reg, b_next;     // multiplier, consumed LSB first
  logic             b_is_zero;

  // The zero test on the shifting multiplier gives early termination.
  assign b_is_zero = (b_reg == '0);

  // State and datapath registers; reset wins over everything, mid-run too.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      pp_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      state_reg <= state_next;
      pp_reg    <= pp_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
    end
  end

  // Next-state, datapath updates and decoded status outputs.
  always_comb begin
    state_next = state_reg;
    pp_next    = pp_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    done       = 1'b0;
    busy       = 1'b0;

    unique case (state_reg)
      IDLE: begin
        // Operands are sampled only here, so later A/B or init activity
        // cannot disturb a running operation.
        if (init) begin
          a_next     = {{WIDTH{1'b0}}, A};
          b_next     = B;
          pp_next    = '0;
          state_next = CHECK;
        end
      end

      CHECK: begin
        busy = 1'b1;
        if (b_is_zero) begin
          state_next = DONE;
        end else if (b_reg[0]) begin
          state_next = ADD;
        end else begin
          state_next = SHIFT;
        end
      end

      ADD: begin
        busy = 1'b1;
        // The product width holds (2^WIDTH-1)^2, so no carry out is kept.
        pp_next    = pp_reg + a_reg;
        state_next = SHIFT;
      end

      SHIFT: begin
        busy       = 1'b1;
        a_next     = a_reg << 1;
        b_next     = b_reg >> 1;
        state_next = CHECK;
      end

      DONE: begin
        // A single strobe cycle; init seen here is deliberately ignored.
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign pp = pp_reg;

endmodule
